// File: rtl/fsm_pkg.sv
// ============================================================================
// Module      : fsm_pkg
// Description : Shared types for the Moore FSM symbol stream and its packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_pkg;

  localparam int SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } out_state_t;

endpackage

`default_nettype wire

// File: rtl/sym_word_packer.sv
// ============================================================================
// Module      : sym_word_packer
// Description : Packs consecutive symbols MSB-first into words on a valid/ready
//               port; supports partial-word flush and flags dropped words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sym_word_packer
  import fsm_pkg::*;
#(
  parameter int SYM_W         = fsm_pkg::SYM_W,
  parameter int SYMS_PER_WORD = 4,
  localparam int WORD_W       = SYM_W * SYMS_PER_WORD,
  localparam int CNT_W        = $clog2(SYMS_PER_WORD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              overflow
);

  out_state_t        state;
  out_state_t        state_nxt;
  logic [WORD_W-1:0] acc;
  logic [CNT_W-1:0]  idx;

  logic [WORD_W-1:0] packed_word;
  logic [CNT_W-1:0]  idx_after;
  logic              word_done;
  logic              flush_emit;
  logic              new_word;
  logic              load;
  logic              drop;

  // The incoming symbol is merged before any flush so a coincident flush sees it.
  always_comb begin
    packed_word = acc;
    for (int k = 0; k < SYMS_PER_WORD; k++) begin
      if (sym_valid && (idx == CNT_W'(k))) begin
        packed_word[WORD_W-1-k*SYM_W -: SYM_W] = sym;
      end
    end
    idx_after  = sym_valid ? (idx + CNT_W'(1)) : idx;
    word_done  = sym_valid && (idx == CNT_W'(SYMS_PER_WORD - 1));
    flush_emit = flush && !word_done && (idx_after != '0);
    new_word   = word_done || flush_emit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      idx <= '0;
    end else if (new_word) begin
      acc <= '0;
      idx <= '0;
    end else begin
      acc <= packed_word;
      idx <= idx_after;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    out_valid = 1'b0;
    case (state)
      EMPTY: begin
        if (new_word) begin
          load      = 1'b1;
          state_nxt = LOADED;
        end
      end
      LOADED: begin
        out_valid = 1'b1;
        if (out_ready) begin
          load      = new_word;
          state_nxt = new_word ? LOADED : EMPTY;
        end else begin
          drop = new_word;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= packed_word;
        out_count <= idx_after;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sym_word_packer.sv
// ============================================================================
// Module      : tb_sym_word_packer
// Description : Directed self-checking bench for sym_word_packer (SYM_W=2, 4 syms/word).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sym_word_packer;

  logic       clk;
  logic       rst;
  logic       sym_valid;
  logic [1:0] sym;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic       overflow;

  int n_checks;
  int n_fail;

  sym_word_packer #(.SYM_W(2), .SYMS_PER_WORD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym       (sym),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic tick(input logic v, input logic [1:0] s, input logic f);
    sym_valid = v;
    sym       = s;
    flush     = f;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] stream_syms [12];
    logic [7:0] stream_words [3];
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    sym_valid = 1'b0;
    sym       = 2'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #3;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_count", 32'(out_count), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic pack 3,1,0,2 -> D2
    tick(1, 2'd3, 0);
    check("basic_not_yet", 32'(out_valid), 32'd0);
    tick(1, 2'd1, 0);
    tick(1, 2'd0, 0);
    tick(1, 2'd2, 0);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'hD2);
    check("basic_count", 32'(out_count), 32'd4);
    tick(0, 2'd0, 0);
    check("basic_drained", 32'(out_valid), 32'd0);

    // Flush partial 1,3 -> 70
    tick(1, 2'd1, 0);
    tick(1, 2'd3, 0);
    tick(0, 2'd0, 1);
    check("flush_valid", 32'(out_valid), 32'd1);
    check("flush_data", 32'(out_data), 32'h70);
    check("flush_count", 32'(out_count), 32'd2);
    tick(0, 2'd0, 1);
    check("flush_empty_none", 32'(out_valid), 32'd0);

    // Back-pressure overflow
    out_ready = 1'b0;
    tick(1, 2'd0, 0);
    tick(1, 2'd1, 0);
    tick(1, 2'd2, 0);
    tick(1, 2'd3, 0);
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_data", 32'(out_data), 32'h1B);
    check("bp_no_ovf_yet", 32'(overflow), 32'd0);
    tick(1, 2'd3, 0);
    tick(1, 2'd2, 0);
    tick(1, 2'd1, 0);
    check("bp_ovf_before_8th", 32'(overflow), 32'd0);
    tick(1, 2'd0, 0);
    check("bp_held_data", 32'(out_data), 32'h1B);
    check("bp_held_count", 32'(out_count), 32'd4);
    check("bp_ovf_set", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    tick(0, 2'd0, 0);
    check("bp_drained_once", 32'(out_valid), 32'd0);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Async reset mid-word
    tick(1, 2'd3, 0);
    tick(1, 2'd3, 0);
    #2;
    rst = 1'b0;
    #1;
    check("areset_valid", 32'(out_valid), 32'd0);
    check("areset_data", 32'(out_data), 32'd0);
    check("areset_ovf", 32'(overflow), 32'd0);
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick(1, 2'd2, 0);
    tick(1, 2'd2, 0);
    tick(1, 2'd2, 0);
    check("areset_restart_idle", 32'(out_valid), 32'd0);
    tick(1, 2'd2, 0);
    check("areset_word_valid", 32'(out_valid), 32'd1);
    check("areset_word_data", 32'(out_data), 32'hAA);
    check("areset_word_count", 32'(out_count), 32'd4);
    tick(0, 2'd0, 0);

    // Streaming: 12 back-to-back symbols -> D2, 1B, AA
    stream_syms  = '{8'd3, 8'd1, 8'd0, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2};
    stream_words = '{8'hD2, 8'h1B, 8'hAA};
    for (int i = 0; i < 12; i++) begin
      tick(1, stream_syms[i][1:0], 0);
      if ((i % 4) == 3) begin
        check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
        check($sformatf("stream_data_%0d", i), 32'(out_data), 32'(stream_words[i/4]));
      end else begin
        check($sformatf("stream_gap_%0d", i), 32'(out_valid), 32'd0);
      end
    end
    tick(0, 2'd0, 0);
    check("stream_ovf", 32'(overflow), 32'd0);

    // Flush coincident with the completing symbol
    tick(1, 2'd1, 0);
    tick(1, 2'd1, 0);
    tick(1, 2'd1, 0);
    tick(1, 2'd1, 1);
    check("flushfull_data", 32'(out_data), 32'h55);
    check("flushfull_count", 32'(out_count), 32'd4);
    tick(0, 2'd0, 0);
    check("flushfull_no_extra", 32'(out_valid), 32'd0);

    // Flush coincident with a lone first symbol
    tick(1, 2'd3, 1);
    check("flush1_valid", 32'(out_valid), 32'd1);
    check("flush1_data", 32'(out_data), 32'hC0);
    check("flush1_count", 32'(out_count), 32'd1);
    tick(0, 2'd0, 0);
    check("flush1_drained", 32'(out_valid), 32'd0);
    check("final_ovf", 32'(overflow), 32'd0);

    do_reset();
    check("final_reset_count", 32'(out_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
